// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - PLL-lock qualified, staggered multi-domain reset sequencer.
// Optional 1 Hz status blink in RUN is built only with RST_SEQ_HEARTBEAT_EN defined.
module rst_sequencer #(
  parameter int CLK_MHZ        = 50,
  parameter int N_DOMAINS      = 2,
  parameter int STRETCH_CYCLES = 64,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOCK_FILTER    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 soft_rst,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 ready,
  output logic [2:0]           state,
  output logic [7:0]           lock_loss_cnt,
  output logic                 heartbeat
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // A single domain still spends one cycle in RELEASE before RUN.
  localparam int STAG_LAST = (N_DOMAINS == 1) ? 1 : (N_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int GW = $clog2(STAG_LAST + 1);

  localparam logic [FW-1:0] FILT_END = FW'(LOCK_FILTER - 1);
  localparam logic [SW-1:0] STR_END  = SW'(STRETCH_CYCLES - 1);
  localparam logic [GW-1:0] STAG_END = GW'(STAG_LAST);

  state_t st_q, st_n;
  logic locked_m, locked_s;
  logic [FW-1:0] filt_q, filt_n;
  logic [SW-1:0] str_q, str_n;
  logic [GW-1:0] stag_q, stag_n, stag_inc;
  logic [N_DOMAINS-1:0] rst_out_n;
  logic ready_n;
  logic [7:0] lcnt_n;
  logic lose;

  function automatic logic [N_DOMAINS-1:0] stagger_mask(input logic [GW-1:0] elapsed);
    logic [N_DOMAINS-1:0] m;
    for (int i = 0; i < N_DOMAINS; i++) begin
      m[i] = (elapsed < GW'(i * STAGGER_CYCLES));
    end
    return m;
  endfunction

  always_comb begin
    st_n      = st_q;
    filt_n    = filt_q;
    str_n     = str_q;
    stag_n    = stag_q;
    rst_out_n = '1;
    ready_n   = 1'b0;
    lcnt_n    = lock_loss_cnt;
    stag_inc  = stag_q + 1'b1;
    lose      = !locked_s && (st_q == STRETCH || st_q == RELEASE || st_q == RUN);

    // Lock loss outranks everything, including a coincident soft reset.
    if (lose) begin
      st_n   = WAIT_LOCK;
      filt_n = '0;
      if (lock_loss_cnt != 8'hFF) begin
        lcnt_n = lock_loss_cnt + 1'b1;
      end
    end else begin
      case (st_q)
        HOLD: st_n = WAIT_LOCK;
        WAIT_LOCK: begin
          if (!locked_s) begin
            filt_n = '0;
          end else if (filt_q == FILT_END) begin
            st_n   = STRETCH;
            filt_n = '0;
            str_n  = '0;
          end else begin
            filt_n = filt_q + 1'b1;
          end
        end
        STRETCH: begin
          if (str_q == STR_END) begin
            st_n      = RELEASE;
            stag_n    = '0;
            rst_out_n = stagger_mask('0);
          end else begin
            str_n = str_q + 1'b1;
          end
        end
        RELEASE: begin
          if (stag_inc == STAG_END) begin
            st_n      = RUN;
            rst_out_n = '0;
            ready_n   = 1'b1;
          end else begin
            stag_n    = stag_inc;
            rst_out_n = stagger_mask(stag_inc);
          end
        end
        RUN: begin
          if (soft_rst) begin
            st_n  = STRETCH;
            str_n = '0;
          end else begin
            rst_out_n = '0;
            ready_n   = 1'b1;
          end
        end
        default: st_n = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= HOLD;
      locked_m      <= 1'b0;
      locked_s      <= 1'b0;
      filt_q        <= '0;
      str_q         <= '0;
      stag_q        <= '0;
      rst_out       <= '1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      locked_m      <= locked;
      locked_s      <= locked_m;
      st_q          <= st_n;
      filt_q        <= filt_n;
      str_q         <= str_n;
      stag_q        <= stag_n;
      rst_out       <= rst_out_n;
      ready         <= ready_n;
      lock_loss_cnt <= lcnt_n;
    end
  end

  assign state = st_q;

`ifdef RST_SEQ_HEARTBEAT_EN
  localparam int HB_HALF = CLK_MHZ * 500000;
  logic [31:0] hb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt    <= 32'd0;
      heartbeat <= 1'b0;
    end else if (st_n != RUN) begin
      hb_cnt    <= 32'd0;
      heartbeat <= 1'b0;
    end else if (hb_cnt == 32'(HB_HALF - 1)) begin
      hb_cnt    <= 32'd0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end
`else
  assign heartbeat = 1'b0 & (CLK_MHZ > 0);
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer (3 domains, short timings).
module tb_rst_sequencer;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       locked   = 1'b0;
  logic       soft_rst = 1'b0;
  logic [2:0] rst_out;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;
  logic       heartbeat;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [2:0] ro;
    logic       rdy;
    logic [7:0] lc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   vectors = 0;
  int   errs    = 0;
  bit   mon_en  = 1'b0;

  rst_sequencer #(
    .CLK_MHZ(50), .N_DOMAINS(3), .STRETCH_CYCLES(16), .STAGGER_CYCLES(4), .LOCK_FILTER(8)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .soft_rst(soft_rst),
    .rst_out(rst_out), .ready(ready), .state(state),
    .lock_loss_cnt(lock_loss_cnt), .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ev(input int c, input logic [2:0] s, input logic [2:0] r,
                    input logic y, input logic [7:0] l);
    exp_t e;
    e.cyc = c; e.st = s; e.ro = r; e.rdy = y; e.lc = l;
    sb.push_back(e);
  endtask

  // Cold-start sequence from the negedge at which locked rises (cycle c).
  task automatic seq_from_lock(input int c, input logic [7:0] l);
    ev(c + 10, 3'd2, 3'b111, 1'b0, l);
    ev(c + 26, 3'd3, 3'b110, 1'b0, l);
    ev(c + 30, 3'd3, 3'b100, 1'b0, l);
    ev(c + 34, 3'd4, 3'b000, 1'b1, l);
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state !== s) begin
      errs++;
      $display("FAIL wait_state cyc=%0d: state=%0d, required %0d within %0d cycles", cyc, state, s, budget);
    end
  endtask

  function automatic logic [7:0] sat(input int k);
    return (k > 255) ? 8'd255 : 8'(k);
  endfunction

  initial begin : monitor
    logic [15:0] prev, cur;
    exp_t e;
    prev = 'x;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      cur = {state, rst_out, ready, lock_loss_cnt, heartbeat};
      if (mon_en && cur !== prev) begin
        prev = cur;
        vectors++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL unexpected_event cyc=%0d state=%0d rst_out=%b ready=%b lock_loss_cnt=%0d",
                   cyc, state, rst_out, ready, lock_loss_cnt);
        end else begin
          e = sb.pop_front();
          if (state !== e.st || rst_out !== e.ro || ready !== e.rdy || lock_loss_cnt !== e.lc ||
              heartbeat !== 1'b0 || (e.cyc >= 0 && cyc != e.cyc)) begin
            errs++;
            $display("FAIL event cyc=%0d state=%0d rst_out=%b ready=%b lock_loss_cnt=%0d heartbeat=%b; required cyc=%0d state=%0d rst_out=%b ready=%b lock_loss_cnt=%0d heartbeat=0",
                     cyc, state, rst_out, ready, lock_loss_cnt, heartbeat, e.cyc, e.st, e.ro, e.rdy, e.lc);
          end
        end
      end
    end
  end

  initial begin : stim
    int c;
    #2 rst = 1'b1;
    ev(-1, 3'd0, 3'b111, 1'b0, 8'd0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // cold boot
    c = cyc;
    ev(c + 1, 3'd1, 3'b111, 1'b0, 8'd0);
    rst = 1'b0;
    at_cycle(c + 3);
    c = cyc;
    seq_from_lock(c, 8'd0);
    locked = 1'b1;

    // lock loss in RUN
    at_cycle(c + 40);
    c = cyc;
    ev(c + 3, 3'd1, 3'b111, 1'b0, 8'd1);
    locked = 1'b0;

    // lock glitch: 5 high, 1 low, then high; filter restarts from the final rise
    at_cycle(c + 6);
    c = cyc;
    seq_from_lock(c + 6, 8'd1);
    locked = 1'b1;
    at_cycle(c + 5);
    locked = 1'b0;
    at_cycle(c + 6);
    locked = 1'b1;

    // soft reset in RUN skips the filter
    at_cycle(c + 44);
    c = cyc;
    ev(c + 1,  3'd2, 3'b111, 1'b0, 8'd1);
    ev(c + 17, 3'd3, 3'b110, 1'b0, 8'd1);
    ev(c + 21, 3'd3, 3'b100, 1'b0, 8'd1);
    ev(c + 25, 3'd4, 3'b000, 1'b1, 8'd1);
    soft_rst = 1'b1;
    at_cycle(c + 1);
    soft_rst = 1'b0;

    // soft reset in WAIT_LOCK is ignored
    at_cycle(c + 30);
    c = cyc;
    ev(c + 3, 3'd1, 3'b111, 1'b0, 8'd2);
    locked = 1'b0;
    at_cycle(c + 5);
    soft_rst = 1'b1;
    at_cycle(c + 6);
    soft_rst = 1'b0;
    at_cycle(c + 10);
    c = cyc;
    seq_from_lock(c, 8'd2);
    locked = 1'b1;

    // soft reset coinciding with synchronised lock loss: lock loss wins
    at_cycle(c + 48);
    c = cyc;
    ev(c + 3, 3'd1, 3'b111, 1'b0, 8'd3);
    locked = 1'b0;
    at_cycle(c + 2);
    soft_rst = 1'b1;
    at_cycle(c + 3);
    soft_rst = 1'b0;

    // repeated lock losses from STRETCH up to 300 total
    for (int k = 4; k <= 300; k++) begin
      ev(-1, 3'd2, 3'b111, 1'b0, sat(k - 1));
      locked = 1'b1;
      wait_state(3'd2, 40);
      ev(-1, 3'd1, 3'b111, 1'b0, sat(k));
      locked = 1'b0;
      wait_state(3'd1, 20);
    end

    // async reset while rst_out=100
    @(negedge clk);
    c = cyc;
    ev(c + 10, 3'd2, 3'b111, 1'b0, 8'd255);
    ev(c + 26, 3'd3, 3'b110, 1'b0, 8'd255);
    ev(c + 30, 3'd3, 3'b100, 1'b0, 8'd255);
    locked = 1'b1;
    at_cycle(c + 30);
    ev(c + 30, 3'd0, 3'b111, 1'b0, 8'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    locked = 1'b0;
    c = cyc;
    ev(c + 1, 3'd1, 3'b111, 1'b0, 8'd0);
    rst = 1'b0;
    at_cycle(c + 5);

    vectors++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL leftover_expectations: %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run exceeded 90000 cycles at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
